biquad_cascade: RTL and testbench

- Time-multiplexed IIR equalizer engine between the audio controller's ADC sample output and its DAC sample input.
- Holds NUM_STAGES Direct Form I biquad sections.
- Coefficient sets arrive from io_controller (b0, b1, b2, a1, a2, 18-bit signed) and are committed atomically between samples.
- One shared multiplier processes each accepted sample through all sections in sequence.

---
 rtl/biquad_cascade.sv | 206 ++++++++++++++++++++
 tb/tb_biquad_cascade.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_cascade.sv
// ---------------------------------------------------------------------------
// biquad_cascade
// Time-multiplexed IIR equalizer: NUM_STAGES Direct Form I biquad sections
// evaluated one after another on a single shared multiplier. Each section
// takes 5 multiply-accumulate cycles plus one write-back cycle.
//
// Ports:
//   Clk                  system clock
//   Reset_n              asynchronous active-low reset
//   dsp_enable           1 = filter the sample, 0 = pass it straight through
//   in_sample/in_valid   input sample and its strobe (taken only when idle)
//   in_ready             engine idle, next sample may be presented
//   out_sample           last result, held until the next one
//   out_valid            one-cycle strobe marking a new result
//   coef_we/coef_stage   write b0,b1,b2,a1,a2 into the pending bank
//   coefficients_updated one-cycle pulse when pending bank becomes active
// ---------------------------------------------------------------------------
module biquad_cascade #(
    parameter int NUM_STAGES = 5,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 18,
    parameter int ACC_W      = 40
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     dsp_enable,
    input  logic signed [DATA_W-1:0] in_sample,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_valid,
    input  logic                     coef_we,
    input  logic [2:0]               coef_stage,
    input  logic [COEF_W-1:0]        b0,
    input  logic [COEF_W-1:0]        b1,
    input  logic [COEF_W-1:0]        b2,
    input  logic [COEF_W-1:0]        a1,
    input  logic [COEF_W-1:0]        a2,
    output logic                     coefficients_updated
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int FRAC   = COEF_W - 2;
    localparam logic [COEF_W-1:0] COEF_ONE   = COEF_W'(1) << FRAC;
    localparam logic [2:0]        LAST_STAGE = 3'(NUM_STAGES - 1);

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_WB, S_DONE, S_BYP} state_t;

    typedef struct packed {
        logic [COEF_W-1:0] b0;
        logic [COEF_W-1:0] b1;
        logic [COEF_W-1:0] b2;
        logic [COEF_W-1:0] a1;
        logic [COEF_W-1:0] a2;
    } coef_t;

    localparam coef_t IDENTITY = '{b0: COEF_ONE, b1: '0, b2: '0, a1: '0, a2: '0};

    state_t state, next_state;

    coef_t act_bank  [NUM_STAGES];
    coef_t pend_bank [NUM_STAGES];
    logic  pending_flag;

    logic signed [DATA_W-1:0] x1 [NUM_STAGES];
    logic signed [DATA_W-1:0] x2 [NUM_STAGES];
    logic signed [DATA_W-1:0] y1 [NUM_STAGES];
    logic signed [DATA_W-1:0] y2 [NUM_STAGES];

    logic [2:0]               stage;
    logic [2:0]               tap;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] x_cur;

    logic                     commit;
    logic                     coef_ok;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [DATA_W-1:0] data_sel;
    logic                     subtract;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] y_sat;

    // Pending bank is copied whenever the engine sits idle with new data;
    // the copy reads the pending bank before any same-cycle write lands.
    assign commit  = (state == S_IDLE) && pending_flag;
    assign coef_ok = coef_we && (int'(coef_stage) < NUM_STAGES);

    assign in_ready             = (state == S_IDLE);
    assign out_valid            = (state == S_DONE) || (state == S_BYP);
    assign coefficients_updated = commit;

    // Tap operand selection: b0*x, b1*x1, b2*x2, then a1*y1, a2*y2 subtracted.
    always_comb begin
        coef_sel = '0;
        data_sel = '0;
        subtract = 1'b0;
        case (tap)
            3'd0: begin coef_sel = act_bank[stage].b0; data_sel = x_cur;     end
            3'd1: begin coef_sel = act_bank[stage].b1; data_sel = x1[stage]; end
            3'd2: begin coef_sel = act_bank[stage].b2; data_sel = x2[stage]; end
            3'd3: begin coef_sel = act_bank[stage].a1; data_sel = y1[stage]; subtract = 1'b1; end
            3'd4: begin coef_sel = act_bank[stage].a2; data_sel = y2[stage]; subtract = 1'b1; end
            default: ;
        endcase
    end

    assign prod = PROD_W'(coef_sel) * PROD_W'(data_sel);
    assign term = subtract ? -ACC_W'(prod) : ACC_W'(prod);

    // Saturate when the bits above the output sign bit are not all copies of it.
    assign shifted = acc >>> FRAC;
    always_comb begin
        y_sat = shifted[DATA_W-1:0];
        if (!((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]))) begin
            y_sat = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = dsp_enable ? S_MAC : S_BYP;
            S_MAC:   if (tap == 3'd4) next_state = S_WB;
            S_WB:    next_state = (stage == LAST_STAGE) ? S_DONE : S_MAC;
            S_DONE:  next_state = S_IDLE;
            S_BYP:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Coefficient banks, histories and the MAC datapath
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                act_bank[i]  <= IDENTITY;
                pend_bank[i] <= IDENTITY;
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
            pending_flag <= 1'b0;
            stage        <= '0;
            tap          <= '0;
            acc          <= '0;
            x_cur        <= '0;
            out_sample   <= '0;
        end else begin
            if (coef_ok) begin
                pend_bank[coef_stage] <= '{b0: b0, b1: b1, b2: b2, a1: a1, a2: a2};
            end
            if (commit) begin
                act_bank <= pend_bank;
            end
            if (coef_ok)     pending_flag <= 1'b1;
            else if (commit) pending_flag <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_cur <= in_sample;
                        stage <= '0;
                        tap   <= '0;
                        if (!dsp_enable) out_sample <= in_sample;
                    end
                end
                S_MAC: begin
                    acc <= (tap == 3'd0) ? term : acc + term;
                    tap <= tap + 3'd1;
                end
                S_WB: begin
                    x2[stage] <= x1[stage];
                    x1[stage] <= x_cur;
                    y2[stage] <= y1[stage];
                    y1[stage] <= y_sat;
                    x_cur     <= y_sat;
                    tap       <= '0;
                    // Result is registered on entry to DONE so it is stable
                    // during the out_valid cycle.
                    if (stage == LAST_STAGE) out_sample <= y_sat;
                    else                     stage      <= stage + 3'd1;
                end
                S_BYP: begin
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        x1[i] <= '0;
                        x2[i] <= '0;
                        y1[i] <= '0;
                        y2[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_biquad_cascade.sv
// ---------------------------------------------------------------------------
// tb_biquad_cascade
// Self-checking bench for biquad_cascade. Expected results and their due
// cycle are queued when a sample is accepted; a monitor pops and compares
// them on every out_valid.
// ---------------------------------------------------------------------------
module tb_biquad_cascade;

    logic               Clk;
    logic               Reset_n;
    logic               dsp_enable;
    logic signed [15:0] in_sample;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_sample;
    logic               out_valid;
    logic               coef_we;
    logic [2:0]         coef_stage;
    logic [17:0]        b0, b1, b2, a1, a2;
    logic               coefficients_updated;

    typedef struct {
        logic signed [15:0] val;
        int                 due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   upd_count = 0;

    biquad_cascade dut (
        .Clk                  (Clk),
        .Reset_n              (Reset_n),
        .dsp_enable           (dsp_enable),
        .in_sample            (in_sample),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .out_sample           (out_sample),
        .out_valid            (out_valid),
        .coef_we              (coef_we),
        .coef_stage           (coef_stage),
        .b0                   (b0),
        .b1                   (b1),
        .b2                   (b2),
        .a1                   (a1),
        .a2                   (a2),
        .coefficients_updated (coefficients_updated)
    );

    // 50 MHz clock
    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard monitor: every out_valid must match the head of the queue,
    // both in value and in the cycle it appears.
    always @(negedge Clk) begin
        if (Reset_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_out_valid: out_sample=%0d at cycle %0d, required no output", out_sample, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (out_sample !== mon_e.val || cyc != mon_e.due) begin
                    errors++;
                    $display("[TB] FAIL result: got %0d at cycle %0d, required %0d at cycle %0d",
                             out_sample, cyc, mon_e.val, mon_e.due);
                end
            end
        end
    end

    always @(negedge Clk) if (coefficients_updated) upd_count++;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n  = 1'b0;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        repeat (3) tick();
        sb.delete();
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic write_coef(input logic [2:0] st, input logic [17:0] c0, input logic [17:0] c1,
                              input logic [17:0] c2, input logic [17:0] d1, input logic [17:0] d2);
        coef_stage = st;
        b0 = c0; b1 = c1; b2 = c2; a1 = d1; a2 = d2;
        coef_we = 1'b1;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_ready: in_ready=%0b after 100 cycles, required 1", in_ready);
        end
    endtask

    task automatic send(input logic signed [15:0] s, input logic signed [15:0] e, input bit byp);
        exp_t x;
        wait_ready();
        in_sample = s;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        x.val = e;
        x.due = byp ? cyc : cyc + 30;
        sb.push_back(x);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL in_ready_after_accept: got %0b, required 0", in_ready);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d results outstanding after 100 cycles, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_upd(input int expected, input string name);
        checks++;
        if (upd_count !== expected) begin
            errors++;
            $display("[TB] FAIL %s: coefficients_updated pulses %0d, required %0d", name, upd_count, expected);
        end
    endtask

    task automatic impulse_seq();
        send(16'sd16384, 16'sd16384, 1'b0);
        send(16'sd0,     16'sd8192,  1'b0);
        send(16'sd0,     16'sd4096,  1'b0);
        send(16'sd0,     16'sd2048,  1'b0);
        drain();
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); end
        if (out_sample !== 16'sd0) begin errors++; $display("[TB] FAIL reset_out_sample: got %0d, required 0", out_sample); end
        if (coefficients_updated !== 1'b0) begin errors++; $display("[TB] FAIL reset_coef_upd: got %0b, required 0", coefficients_updated); end
    endtask

    task automatic test_identity();
        dsp_enable = 1'b1;
        send(16'sd12345, 16'sd12345, 1'b0);
        repeat (5) tick();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_in_ready: got %0b, required 0", in_ready); end
        drain();
    endtask

    task automatic test_saturation();
        int u0 = upd_count;
        write_coef(3'd0, 18'h1FFFF, 18'h0, 18'h0, 18'h0, 18'h0);
        repeat (2) tick();
        check_upd(u0 + 1, "sat_commit");
        send(16'sd20000,  16'sd32767,  1'b0);
        send(-16'sd20000, -16'sd32768, 1'b0);
        drain();
    endtask

    task automatic test_impulse();
        int u0;
        do_reset();
        u0 = upd_count;
        write_coef(3'd0, 18'h10000, 18'h0, 18'h0, 18'h38000, 18'h0);
        repeat (2) tick();
        check_upd(u0 + 1, "impulse_commit");
        impulse_seq();
    endtask

    task automatic test_bypass();
        dsp_enable = 1'b0;
        send(-16'sd7, -16'sd7, 1'b1);
        drain();
        dsp_enable = 1'b1;
        impulse_seq();
    endtask

    task automatic test_simultaneous_commit();
        int u0;
        exp_t x;
        do_reset();
        u0 = upd_count;
        send(16'sd111, 16'sd111, 1'b0);
        repeat (3) tick();
        write_coef(3'd0, 18'h08000, 18'h0, 18'h0, 18'h0, 18'h0);
        wait_ready();
        checks++;
        if (coefficients_updated !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_first_commit: coefficients_updated=%0b, required 1", coefficients_updated);
        end
        in_sample  = 16'sd1000;
        in_valid   = 1'b1;
        coef_stage = 3'd0;
        b0 = 18'h04000; b1 = 18'h0; b2 = 18'h0; a1 = 18'h0; a2 = 18'h0;
        coef_we    = 1'b1;
        tick();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        x.val = 16'sd500;
        x.due = cyc + 30;
        sb.push_back(x);
        drain();
        repeat (2) tick();
        check_upd(u0 + 2, "simul_second_commit");
        send(16'sd1000, 16'sd250, 1'b0);
        drain();
    endtask

    task automatic test_invalid_stage();
        int u0;
        do_reset();
        u0 = upd_count;
        write_coef(3'd6, 18'h1FFFF, 18'h0, 18'h0, 18'h0, 18'h0);
        repeat (4) tick();
        check_upd(u0, "invalid_stage_no_commit");
        send(16'sd12345, 16'sd12345, 1'b0);
        drain();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        write_coef(3'd0, 18'h08000, 18'h0, 18'h0, 18'h0, 18'h0);
        repeat (2) tick();
        send(16'sd2000, 16'sd1000, 1'b0);
        drain();
        wait_ready();
        in_sample = 16'sd12345;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (10) tick();
        Reset_n = 1'b0;
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_in_ready: got %0b, required 1", in_ready); end
        if (out_sample !== 16'sd0) begin errors++; $display("[TB] FAIL midreset_out_sample: got %0d, required 0", out_sample); end
        repeat (5) tick();
        Reset_n = 1'b1;
        repeat (40) tick();
        send(16'sd12345, 16'sd12345, 1'b0);
        drain();
    endtask

    initial begin
        Reset_n    = 1'b0;
        dsp_enable = 1'b1;
        in_sample  = '0;
        in_valid   = 1'b0;
        coef_we    = 1'b0;
        coef_stage = '0;
        b0 = '0; b1 = '0; b2 = '0; a1 = '0; a2 = '0;

        $display("[TB] reset");
        test_reset();
        $display("[TB] identity latency");
        test_identity();
        $display("[TB] saturation");
        test_saturation();
        $display("[TB] impulse response");
        test_impulse();
        $display("[TB] bypass");
        test_bypass();
        $display("[TB] simultaneous commit");
        test_simultaneous_commit();
        $display("[TB] invalid stage");
        test_invalid_stage();
        $display("[TB] reset mid-computation");
        test_reset_midflight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
